clk_en_synth: RTL and testbench

- Parametrised multi-channel digital clock-enable synthesiser. Each channel is a fractional-N phase accumulator that derives a slower rate from the single system clock.
- Produces a one-cycle strobe and a near-50% square output per channel.
- Increments can be retuned at runtime through a valid/ready port. A new increment is applied only at the channel's wrap, so the output never glitches.
- Sits beside the board PLL and feeds LCD, audio and sampling logic with pixel/sample enables plus a lock indication.

---
 rtl/clk_en_synth.sv | 125 ++++++++++++
 tb/tb_clk_en_synth.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clk_en_synth.sv
// Multi-channel fractional-N clock-enable synthesiser: per-channel phase
// accumulators with glitch-free runtime retune and a settle/lock indicator.
module clk_en_synth #(
  parameter int unsigned         CHANNELS    = 3,
  parameter int unsigned         ACC_W       = 16,
  parameter logic [ACC_W-1:0]    INC_RESET   = {1'b1, {(ACC_W-1){1'b0}}},
  parameter int unsigned         LOCK_CYCLES = 64,
  localparam int unsigned        CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [ACC_W-1:0]    cfg_inc,
  output logic [CHANNELS-1:0] strobe,
  output logic [CHANNELS-1:0] square,
  output logic                locked
);

  localparam int unsigned LC_W = $clog2(LOCK_CYCLES);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_d [CHANNELS];
  logic [ACC_W-1:0]    inc_q [CHANNELS];
  logic [ACC_W-1:0]    inc_d [CHANNELS];
  logic [ACC_W:0]      sum   [CHANNELS];
  logic [CHANNELS-1:0] carry;
  logic [CHANNELS-1:0] strobe_q, strobe_d;
  logic                pend_q, pend_d;
  logic [CH_W-1:0]     pend_chan_q, pend_chan_d;
  logic [ACC_W-1:0]    pend_inc_q, pend_inc_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [LC_W-1:0]     lock_cnt_q, lock_cnt_d;
  lock_state_e         state_q, state_d;
  logic                locked_q, locked_d;
  logic                accept_valid;

  // Accumulators, pending retune slot and config handshake.
  always_comb begin
    acc_d        = acc_q;
    inc_d        = inc_q;
    strobe_d     = '0;
    pend_d       = pend_q;
    pend_chan_d  = pend_chan_q;
    pend_inc_d   = pend_inc_q;
    carry        = '0;
    accept_valid = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      carry[i] = sum[i][ACC_W];
      if (enable) begin
        acc_d[i] = sum[i][ACC_W-1:0];
        // New increment lands on the wrap (or immediately if the channel is frozen).
        if (pend_q && (pend_chan_q == CH_W'(i)) && (carry[i] || (inc_q[i] == '0))) begin
          inc_d[i] = pend_inc_q;
          pend_d   = 1'b0;
        end
      end
    end
    if (enable) strobe_d = carry;
    if (cfg_valid && cfg_ready_q && (32'(cfg_chan) < CHANNELS)) begin
      accept_valid = 1'b1;
      pend_d       = 1'b1;
      pend_chan_d  = cfg_chan;
      pend_inc_d   = cfg_inc;
    end
    cfg_ready_d = ~pend_d;
  end

  // Lock FSM next-state.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (accept_valid) begin
      state_d    = UNLOCKED;
      lock_cnt_d = '0;
    end else if (enable && !pend_q && (state_q == UNLOCKED)) begin
      if (lock_cnt_q == LC_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
      else lock_cnt_d = lock_cnt_q + LC_W'(1);
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_RESET;
      end
      strobe_q    <= '0;
      pend_q      <= 1'b0;
      pend_chan_q <= '0;
      pend_inc_q  <= '0;
      cfg_ready_q <= 1'b1;
      lock_cnt_q  <= '0;
      state_q     <= UNLOCKED;
      locked_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      strobe_q    <= strobe_d;
      pend_q      <= pend_d;
      pend_chan_q <= pend_chan_d;
      pend_inc_q  <= pend_inc_d;
      cfg_ready_q <= cfg_ready_d;
      lock_cnt_q  <= lock_cnt_d;
      state_q     <= state_d;
      locked_q    <= locked_d;
    end
  end

  always_comb begin
    square = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) square[i] = acc_q[i][ACC_W-1];
  end

  assign strobe    = strobe_q;
  assign cfg_ready = cfg_ready_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_clk_en_synth.sv
// Scoreboarded random/directed bench for clk_en_synth against a phase-arithmetic model.
module tb_clk_en_synth;
  localparam int unsigned CHANNELS    = 3;
  localparam int unsigned ACC_W       = 16;
  localparam int unsigned LOCK_CYCLES = 64;
  localparam int unsigned CH_W        = 2;
  localparam longint unsigned MOD     = 64'd1 << ACC_W;
  localparam longint unsigned INC_RST = 64'h8000;

  logic clk = 1'b0;
  logic rst_n, enable, cfg_valid, cfg_ready, locked;
  logic [CH_W-1:0] cfg_chan;
  logic [ACC_W-1:0] cfg_inc;
  logic [CHANNELS-1:0] strobe, square;

  always #5 clk = ~clk;

  clk_en_synth #(.CHANNELS(CHANNELS), .ACC_W(ACC_W), .INC_RESET(16'h8000),
                 .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_inc(cfg_inc),
    .strobe(strobe), .square(square), .locked(locked));

  typedef struct packed {
    logic [CHANNELS-1:0] strobe;
    logic [CHANNELS-1:0] square;
    logic                locked;
    logic                ready;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int s0_cnt = 0;

  // Reference model: phase = (phase + step) mod 2^ACC_W, overflow is a strobe.
  longint unsigned m_phase [CHANNELS];
  longint unsigned m_step  [CHANNELS];
  bit              m_pend;
  int unsigned     m_pch;
  longint unsigned m_pinc;
  int unsigned     m_settled;
  bit [CHANNELS-1:0] m_wrap, m_sq;
  bit              m_was_pend;
  longint unsigned m_total;
  exp_t            m_e;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin m_phase[i] = 0; m_step[i] = INC_RST; end
      m_pend = 0; m_settled = 0;
      m_e = '{strobe: '0, square: '0, locked: 1'b0, ready: 1'b1};
    end else begin
      m_was_pend = m_pend;
      m_wrap = '0;
      if (enable) begin
        for (int i = 0; i < CHANNELS; i++) begin
          m_total = m_phase[i] + m_step[i];
          m_wrap[i] = (m_total >= MOD);
          m_phase[i] = m_total % MOD;
        end
        if (m_pend && (m_wrap[m_pch] || m_step[m_pch] == 0)) begin
          m_step[m_pch] = m_pinc;
          m_pend = 0;
        end
      end
      if (cfg_valid && !m_was_pend && (int'(cfg_chan) < CHANNELS)) begin
        m_pend = 1; m_pch = cfg_chan; m_pinc = cfg_inc; m_settled = 0;
      end else if (enable && !m_was_pend) begin
        m_settled++;
      end
      for (int i = 0; i < CHANNELS; i++) m_sq[i] = (m_phase[i] >= MOD / 2);
      m_e = '{strobe: m_wrap, square: m_sq, locked: (m_settled >= LOCK_CYCLES),
              ready: !m_pend};
    end
    q.push_back(m_e);
  end

  // Monitor: compare every cycle's outputs against the queued expectation.
  exp_t got, want;
  always @(negedge clk) begin
    got = '{strobe: strobe, square: square, locked: locked, ready: cfg_ready};
    if (strobe[0] === 1'b1) s0_cnt++;
    if (!rst_n) begin
      checks++;
      if (got !== exp_t'{strobe: '0, square: '0, locked: 1'b0, ready: 1'b1}) begin
        failures++;
        $display("FAIL reset_outputs t=%0t got=%b want strobe=0 square=0 locked=0 ready=1", $time, got);
      end
      q.delete();
    end else if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty t=%0t got=%b", $time, got);
    end else begin
      want = q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL outputs t=%0t got strobe=%b square=%b locked=%b ready=%b want strobe=%b square=%b locked=%b ready=%b",
                 $time, got.strobe, got.square, got.locked, got.ready,
                 want.strobe, want.square, want.locked, want.ready);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    while (!cfg_ready && n < budget) begin cyc(1); n++; end
    checks++;
    if (!cfg_ready) begin
      failures++;
      $display("FAIL %s cfg_ready=%b after %0d cycles, required 1", name, cfg_ready, budget);
    end
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [ACC_W-1:0] inc);
    wait_ready("cfg_ready_before_write", 5000);
    cfg_valid = 1'b1; cfg_chan = ch; cfg_inc = inc;
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_inc = '0;
    cyc(3);
    rst_n = 1'b1; enable = 1'b1;
    cyc(70);

    cfg_write(2'd1, 16'h4000);
    wait_ready("ch1_apply", 100);
    cyc(70);

    cfg_write(2'd0, 16'h5556);
    wait_ready("ch0_apply", 100);
    s0_cnt = 0;
    cyc(3000);
    checks++;
    if (s0_cnt < 999 || s0_cnt > 1001) begin
      failures++;
      $display("FAIL ch0_rate strobes=%0d over 3000 cycles, required 999..1001", s0_cnt);
    end

    cfg_write(2'd2, 16'h0000);
    wait_ready("ch2_freeze_apply", 100);
    cyc(20);
    cfg_write(2'd2, 16'h1000);
    wait_ready("ch2_unfreeze_apply", 4);
    cyc(40);

    cfg_write(2'd1, 16'h2000);
    enable = 1'b0;
    cyc(10);
    enable = 1'b1;
    wait_ready("deferred_apply", 100);
    cyc(20);

    cfg_write(2'd3, 16'h1234);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL invalid_chan cfg_ready=%b, required 1", cfg_ready);
    end
    cyc(5);

    cfg_write(2'd0, 16'h3000);
    cyc(1);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);

    for (int k = 0; k < 3000; k++) begin
      enable    = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_chan  = CH_W'($urandom_range(0, 3));
      cfg_inc   = ($urandom_range(0, 5) == 0) ? 16'h0000 : ACC_W'($urandom_range(16'h0800, 16'hffff));
      cyc(1);
    end
    cfg_valid = 1'b0; enable = 1'b1;
    cyc(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
